// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC conversion scheduler.
// ADC_SCHED_AVG_EN (optional) switches CAPTURE to a 4-frame average.
package adc_sched_pkg;

    localparam int ADC_W       = 12;
    localparam int SUM_W       = 14;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISCARD,
        S_CAPTURE,
        S_DELIVER,
        S_ERR
    } state_e;

endpackage

// File: rtl/adc_scheduler_if.sv
// Requester/ADC-side bundle of the scheduler: requests, ADC frames and results.
// master = requesters + ADC front end, slave = scheduler.
interface adc_scheduler_if #(
    parameter int NREQ = adc_sched_pkg::NREQ_DEF
);
    import adc_sched_pkg::*;

    localparam int SEL_W = $clog2(NREQ);

    logic [NREQ-1:0]  req;
    logic [ADC_W-1:0] adc_code;
    logic             adc_new;
    logic [SEL_W-1:0] chan_sel;
    logic [NREQ-1:0]  grant;
    logic [ADC_W-1:0] data;
    logic             data_valid;
    logic             timeout_err;
    logic             busy;

    modport master (
        output req, adc_code, adc_new,
        input  chan_sel, grant, data, data_valid, timeout_err, busy
    );

    modport slave (
        input  req, adc_code, adc_new,
        output chan_sel, grant, data, data_valid, timeout_err, busy
    );

endinterface

// File: rtl/adc_scheduler_rr_arbiter.sv
// Round-robin pick: searches from ptr+1 upward (wrapping) for the first request.
module rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    logic [PW-1:0] idx;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scheduler.sv
// Serialises NREQ requesters onto one muxed ADC; optional ADC_SCHED_AVG_EN averages 4 frames.
//   state     | meaning
//   S_IDLE    | arbitrate pending requests, set mux
//   S_DISCARD | drop first frame after a mux change (settling)
//   S_CAPTURE | take frame(s) for the winner
//   S_DELIVER | one-cycle grant with data_valid
//   S_ERR     | one-cycle grant with timeout_err
module adc_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            ADC_sclk,
    input  logic            reset_n,
    adc_scheduler_if.slave  bus
);

    localparam int SEL_W = $clog2(NREQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] win_q, win_d;
    logic [SEL_W-1:0] chan_sel_q, chan_sel_d;
    logic             chan_ok_q, chan_ok_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [ADC_W-1:0] data_q, data_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             data_valid_q, data_valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_q, busy_d;
`ifdef ADC_SCHED_AVG_EN
    logic [SUM_W-1:0] sum_q, sum_d, sum_nxt;
    logic [1:0]       frm_q, frm_d;
`endif

    logic [NREQ-1:0]  arb_win;
    logic             arb_valid;
    logic [SEL_W-1:0] arb_idx;
    logic [NREQ-1:0]  win_oh;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (SEL_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr_q),
        .win   (arb_win),
        .valid (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_win[i]) arb_idx = SEL_W'(i);
        end
    end

    assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_q;

`ifdef ADC_SCHED_AVG_EN
    assign sum_nxt = sum_q + SUM_W'(bus.adc_code);
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        chan_sel_d    = chan_sel_q;
        chan_ok_d     = chan_ok_q;
        tmr_d         = tmr_q;
        data_d        = data_q;
        grant_d       = '0;
        data_valid_d  = 1'b0;
        timeout_err_d = 1'b0;
`ifdef ADC_SCHED_AVG_EN
        sum_d         = sum_q;
        frm_d         = frm_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    win_d      = arb_idx;
                    chan_sel_d = arb_idx;
                    tmr_d      = TMR_LOAD;
`ifdef ADC_SCHED_AVG_EN
                    sum_d      = '0;
                    frm_d      = '0;
`endif
                    // Mux already parked on a known-good channel: no settling frame needed
                    if (arb_idx == chan_sel_q && chan_ok_q) begin
                        state_d = S_CAPTURE;
                    end else begin
                        state_d   = S_DISCARD;
                        chan_ok_d = 1'b0;
                    end
                end
            end
            S_DISCARD, S_CAPTURE: begin
                // A frame arriving on the terminal-count cycle still wins over the abort
                if (bus.adc_new) begin
                    tmr_d = TMR_LOAD;
                    if (state_q == S_DISCARD) begin
                        state_d = S_CAPTURE;
                    end else begin
`ifdef ADC_SCHED_AVG_EN
                        sum_d = sum_nxt;
                        frm_d = frm_q + 2'd1;
                        if (frm_q == 2'd3) begin
                            data_d       = sum_nxt[SUM_W-1:2];
                            chan_ok_d    = 1'b1;
                            grant_d      = win_oh;
                            data_valid_d = 1'b1;
                            state_d      = S_DELIVER;
                        end
`else
                        data_d       = bus.adc_code;
                        chan_ok_d    = 1'b1;
                        grant_d      = win_oh;
                        data_valid_d = 1'b1;
                        state_d      = S_DELIVER;
`endif
                    end
                end else if (tmr_q == '0) begin
                    chan_ok_d     = 1'b0;
                    grant_d       = win_oh;
                    timeout_err_d = 1'b1;
                    state_d       = S_ERR;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_DELIVER, S_ERR: begin
                ptr_d   = win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ADC_sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= SEL_W'(NREQ - 1);
            win_q         <= '0;
            chan_sel_q    <= '0;
            chan_ok_q     <= 1'b0;
            tmr_q         <= '0;
            data_q        <= '0;
            grant_q       <= '0;
            data_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ADC_SCHED_AVG_EN
            sum_q         <= '0;
            frm_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            chan_sel_q    <= chan_sel_d;
            chan_ok_q     <= chan_ok_d;
            tmr_q         <= tmr_d;
            data_q        <= data_d;
            grant_q       <= grant_d;
            data_valid_q  <= data_valid_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
`ifdef ADC_SCHED_AVG_EN
            sum_q         <= sum_d;
            frm_q         <= frm_d;
`endif
        end
    end

    assign bus.chan_sel    = chan_sel_q;
    assign bus.grant       = grant_q;
    assign bus.data        = data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_adc_scheduler.sv
// Directed bench for adc_scheduler: arbitration order, settling skip, timeout edge, reset abort.
module tb_adc_scheduler;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   fr_cyc[$];
    logic [11:0] fr_code[$];

    adc_scheduler_if #(.NREQ(NREQ)) bus ();

    adc_scheduler #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ADC_sclk (clk),
        .reset_n  (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_fr(input int c, input logic [11:0] code);
        fr_cyc.push_back(c);
        fr_code.push_back(code);
    endtask

    // Captured frame; in averaging builds repeat it so the average equals the code
    task automatic add_cap(input int c, input logic [11:0] code, input int gap);
        add_fr(c, code);
`ifdef ADC_SCHED_AVG_EN
        for (int k = 1; k < 4; k++) add_fr(c + k * gap, code);
`else
        if (gap < 0) add_fr(c, code);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic serve(input logic [3:0] r, input bit keep,
                         output logic [3:0] g, output logic [11:0] d, output logic dv,
                         output logic te, output logic [1:0] cs, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 0;
        g = '0; d = '0; dv = 1'b0; te = 1'b0; cs = '0;
        bus.req = r;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            bus.adc_new = 1'b0;
            if (cyc == 1) chk("busy_start", {31'd0, bus.busy}, 32'd1);
            if (bus.grant != '0) begin
                g    = bus.grant;
                d    = bus.data;
                dv   = bus.data_valid;
                te   = bus.timeout_err;
                cs   = bus.chan_sel;
                done = 1'b1;
                if (!keep) bus.req = bus.req & ~bus.grant;
            end else if (fr_cyc.size() > 0 && fr_cyc[0] == cyc) begin
                bus.adc_new  = 1'b1;
                bus.adc_code = fr_code.pop_front();
                void'(fr_cyc.pop_front());
            end
        end
        chk("op_bound", {31'd0, done}, 32'd1);
        @(negedge clk);
        bus.adc_new = 1'b0;
        chk("grant_gap", {28'd0, bus.grant}, 32'd0);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        fr_cyc.delete();
        fr_code.delete();
    endtask

    task automatic run_op(input string nm, input logic [3:0] r, input bit keep,
                          input logic [3:0] eg, input logic [11:0] ed, input logic edv,
                          input logic ete, input logic [1:0] ecs);
        logic [3:0]  g;
        logic [11:0] d;
        logic        dv, te;
        logic [1:0]  cs;
        int          cyc, ecyc;
        ecyc = (fr_cyc.size() == 0) ? TIMEOUT + 1 : fr_cyc[fr_cyc.size()-1] + 1;
        serve(r, keep, g, d, dv, te, cs, cyc);
        chk({nm, "_grant"}, {28'd0, g}, {28'd0, eg});
        chk({nm, "_data"},  {20'd0, d}, {20'd0, ed});
        chk({nm, "_dv"},    {31'd0, dv}, {31'd0, edv});
        chk({nm, "_terr"},  {31'd0, te}, {31'd0, ete});
        chk({nm, "_chan"},  {30'd0, cs}, {30'd0, ecs});
        chk({nm, "_cycle"}, cyc, ecyc);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_grant"}, {28'd0, bus.grant}, 32'd0);
        chk({nm, "_chan"},  {30'd0, bus.chan_sel}, 32'd0);
        chk({nm, "_data"},  {20'd0, bus.data}, 32'd0);
        chk({nm, "_dv"},    {31'd0, bus.data_valid}, 32'd0);
        chk({nm, "_terr"},  {31'd0, bus.timeout_err}, 32'd0);
        chk({nm, "_busy"},  {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int gcount;
        logic [3:0] exp_g [5];
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.adc_new = 1'b0;
        bus.adc_code = '0;
        do_reset();
        @(negedge clk);
        chk_reset_outs("rst");

        // single requester, frames every 16 cycles: first discarded, second delivered
        add_fr(16, 12'h111);
        add_cap(32, 12'hABC, 16);
        run_op("single", 4'b0001, 1'b0, 4'b0001, 12'hABC, 1'b1, 1'b0, 2'd0);

        // all requesters held: rotation from requester 0 after reset
        do_reset();
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            logic [11:0] code;
            code = 12'h100 + 12'(k);
            add_fr(8, 12'h0F0);
            add_cap(16, code, 8);
            run_op("rr_all", 4'b1111, 1'b1, exp_g[k], code, 1'b1, 1'b0, 2'(k % 4));
        end
        bus.req = '0;

        // requester 2 twice: second op skips settling frame
        add_fr(10, 12'h222);
        add_cap(20, 12'h333, 10);
        run_op("r2_first", 4'b0100, 1'b0, 4'b0100, 12'h333, 1'b1, 1'b0, 2'd2);
        add_cap(10, 12'h444, 10);
        run_op("r2_skip", 4'b0100, 1'b0, 4'b0100, 12'h444, 1'b1, 1'b0, 2'd2);

        // no frames: timeout abort with data held
        run_op("tmo", 4'b0010, 1'b0, 4'b0010, 12'h444, 1'b0, 1'b1, 2'd1);
        add_fr(10, 12'h555);
        add_cap(20, 12'h666, 10);
        run_op("tmo_redisc", 4'b0010, 1'b0, 4'b0010, 12'h666, 1'b1, 1'b0, 2'd1);

        // frame on the last allowed cycle is accepted
        add_cap(64, 12'h777, 64);
        run_op("tmo_edge", 4'b0010, 1'b0, 4'b0010, 12'h777, 1'b1, 1'b0, 2'd1);

        // sparse requests: pointer at 1 so 3 goes before 1
        add_fr(10, 12'h010);
        add_cap(20, 12'h888, 10);
        run_op("rr_sparse3", 4'b1010, 1'b0, 4'b1000, 12'h888, 1'b1, 1'b0, 2'd3);
        add_fr(10, 12'h020);
        add_cap(20, 12'h999, 10);
        run_op("rr_sparse1", 4'b0010, 1'b0, 4'b0010, 12'h999, 1'b1, 1'b0, 2'd1);

        // reset during CAPTURE drops the operation silently
        gcount = 0;
        bus.req = 4'b0001;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            bus.adc_new = 1'b0;
            if (bus.grant != '0) gcount++;
            if (c == 10) begin
                bus.adc_new  = 1'b1;
                bus.adc_code = 12'h321;
            end
        end
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        repeat (3) begin
            @(negedge clk);
            if (bus.grant != '0) gcount++;
        end
        rst_n = 1'b1;
        chk("mid_rst_nogrant", gcount, 0);
        add_fr(10, 12'h0AA);
        add_cap(20, 12'h9AB, 10);
        run_op("post_rst", 4'b0001, 1'b0, 4'b0001, 12'h9AB, 1'b1, 1'b0, 2'd0);

`ifdef ADC_SCHED_AVG_EN
        do_reset();
        add_fr(8, 12'h999);
        add_fr(16, 12'd100);
        add_fr(24, 12'd200);
        add_fr(32, 12'd300);
        add_fr(40, 12'd400);
        run_op("avg", 4'b0001, 1'b0, 4'b0001, 12'd250, 1'b1, 1'b0, 2'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
